// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  // Source selected for the next fetch PC.
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2
  } npc_sel_e;

  // Instructions are word aligned; drop the byte offset of any target.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF->ID bundle: instruction RAM port, hazard controls, redirects and D-stage outputs.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            inst_en;
  logic [XLEN-1:0] inst_addr;
  logic [XLEN-1:0] inst_rdata;
  logic            stallF;
  logic            stallD;
  logic            flushD;
  logic            pcsrcD;
  logic [XLEN-1:0] pcbranchD;
  logic            jumpD;
  logic [XLEN-1:0] pcjumpD;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] instrD;
  logic [XLEN-1:0] pcplus4D;
  logic            validD;

  // Fetch stage side.
  modport master (
    output inst_en, inst_addr, pcF, instrD, pcplus4D, validD,
    input  inst_rdata, stallF, stallD, flushD, pcsrcD, pcbranchD, jumpD, pcjumpD
  );

  // RAM / decode / hazard-unit side.
  modport slave (
    input  inst_en, inst_addr, pcF, instrD, pcplus4D, validD,
    output inst_rdata, stallF, stallD, flushD, pcsrcD, pcbranchD, jumpD, pcjumpD
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Word-wide register with load enable and asynchronous reset to a fixed value.
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  // Load d on enabled edges; reset forces RESET_VAL immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the synchronous instruction RAM,
// applies decode redirects and presents a stall-safe instrD/pcplus4D pair.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  npc_sel_e        npc_sel;
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pcplus4_cur;
  logic [XLEN-1:0] pcplus4_next;
  logic [XLEN-1:0] instr_cur;
  logic [XLEN-1:0] hold_instr;
  logic            hold_vld;
  logic            valid_cur;
  logic            fetch_fire;

  // A fetch fires whenever the PC is allowed to advance and reset is released.
  assign fetch_fire = !rst && !bus.stallF;

  // Redirect priority: jump beats branch beats sequential.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (bus.jumpD) begin
      npc_sel = NPC_JUMP;
    end else if (bus.pcsrcD) begin
      npc_sel = NPC_BRANCH;
    end
  end

  // Select the raw next PC for the chosen source.
  always_comb begin
    pc_target = pc_cur + PC_INC;
    case (npc_sel)
      NPC_JUMP:   pc_target = bus.pcjumpD;
      NPC_BRANCH: pc_target = bus.pcbranchD;
      default:    pc_target = pc_cur + PC_INC;
    endcase
  end

  assign pc_next      = align_word(pc_target);
  assign pcplus4_next = pc_cur + PC_INC;

  // Fetch PC: frozen while stallF, which also discards any redirect that cycle.
  pc_reg #(.RESET_VAL(RESET_PC)) u_pcf (
    .clk (clk),
    .rst (rst),
    .en  (!bus.stallF),
    .d   (pc_next),
    .q   (pc_cur)
  );

  // PC+4 of the word entering D; frozen with the rest of the D slot.
  pc_reg #(.RESET_VAL('0)) u_pcplus4d (
    .clk (clk),
    .rst (rst),
    .en  (!bus.stallD),
    .d   (pcplus4_next),
    .q   (pcplus4_cur)
  );

  // D-slot valid: follows the fetch fire of the cycle just ending; flush wins over stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_cur <= 1'b0;
    end else if (bus.flushD) begin
      valid_cur <= 1'b0;
    end else if (!bus.stallD) begin
      valid_cur <= fetch_fire;
    end
  end

  // Skid register: capture instrD on the first stalled edge because the RAM
  // output is not held while fetch is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld   <= 1'b0;
      hold_instr <= NOP_WORD;
    end else if (bus.flushD || !bus.stallD) begin
      hold_vld   <= 1'b0;
    end else if (!hold_vld) begin
      hold_vld   <= 1'b1;
      hold_instr <= instr_cur;
    end
  end

  // Held word first, then live RAM data for a valid slot, otherwise a bubble.
  always_comb begin
    instr_cur = NOP_WORD;
    if (hold_vld) begin
      instr_cur = hold_instr;
    end else if (valid_cur) begin
      instr_cur = bus.inst_rdata;
    end
  end

  assign bus.inst_en   = fetch_fire;
  assign bus.inst_addr = pc_cur;
  assign bus.pcF       = pc_cur;
  assign bus.instrD    = instr_cur;
  assign bus.pcplus4D  = pcplus4_cur;
  assign bus.validD    = valid_cur;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// hazards/redirects compared against a slot-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic clk;
  logic rst;
  fetch_stage_if bus();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: fetch PC and the contents of the decode slot.
  logic [31:0] m_pc;
  logic        m_dvalid;
  logic [31:0] m_dinstr;
  logic [31:0] m_dpc4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word i holds 0x1000_0000 + i.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous RAM, 1-cycle latency; output is scrambled when not enabled.
  always @(posedge clk) begin
    if (bus.inst_en) bus.inst_rdata <= ram_word(bus.inst_addr);
    else             bus.inst_rdata <= $urandom;
  end

  task automatic model_reset();
    m_pc     = RST_PC;
    m_dvalid = 1'b0;
    m_dinstr = NOP_W;
    m_dpc4   = 32'h0;
  endtask

  // One clock of the reference model using the inputs currently applied.
  task automatic model_step();
    logic [31:0] pc_now;
    pc_now = m_pc;
    if (bus.flushD) begin
      m_dvalid = 1'b0;
      m_dinstr = NOP_W;
    end else if (!bus.stallD) begin
      m_dvalid = !bus.stallF;
      m_dinstr = bus.stallF ? NOP_W : ram_word(pc_now);
    end
    if (!bus.stallD) m_dpc4 = pc_now + 32'd4;
    if (!bus.stallF) begin
      if (bus.jumpD)       m_pc = bus.pcjumpD;
      else if (bus.pcsrcD) m_pc = bus.pcbranchD;
      else                 m_pc = pc_now + 32'd4;
      m_pc[1:0] = 2'b00;
    end
  endtask

  // Apply one cycle of inputs at the falling edge, settle, log the cycle.
  task automatic drive(input logic stf, input logic std, input logic fl,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
    @(negedge clk);
    rst           = 1'b0;
    bus.stallF    = stf;
    bus.stallD    = std;
    bus.flushD    = fl;
    bus.pcsrcD    = br;
    bus.pcbranchD = bt;
    bus.jumpD     = jp;
    bus.pcjumpD   = jt;
    #1;
    $display("cyc %0d stF=%b stD=%b fl=%b br=%b jp=%b pcF=%h en=%b instrD=%h vD=%b p4D=%h",
             cyc, stf, std, fl, br, jp, bus.pcF, bus.inst_en, bus.instrD, bus.validD, bus.pcplus4D);
    cyc++;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.stallF = 1'b0; bus.stallD = 1'b0; bus.flushD = 1'b0;
    bus.pcsrcD = 1'b0; bus.jumpD = 1'b0;
    #1;
    model_reset();
    n_checks += 5;
    if (bus.pcF !== RST_PC)     begin n_fail++; $display("FAIL reset_pcF got %h want %h", bus.pcF, RST_PC); end
    if (bus.inst_en !== 1'b0)   begin n_fail++; $display("FAIL reset_inst_en got %b want 0", bus.inst_en); end
    if (bus.validD !== 1'b0)    begin n_fail++; $display("FAIL reset_validD got %b want 0", bus.validD); end
    if (bus.instrD !== NOP_W)   begin n_fail++; $display("FAIL reset_instrD got %h want %h", bus.instrD, NOP_W); end
    if (bus.pcplus4D !== 32'h0) begin n_fail++; $display("FAIL reset_pcplus4D got %h want 0", bus.pcplus4D); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.pcF !== RST_PC) begin n_fail++; $display("FAIL reset_hold_pcF got %h want %h", bus.pcF, RST_PC); end
  endtask

  // Straight-line fetch from reset: pcF 0,4,8..; instrD NOP then word 0,1,..
  task automatic test_sequential(input int n);
    logic [31:0] e_instr;
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      e_instr = (k == 0) ? NOP_W : 32'h1000_0000 + 32'(k - 1);
      n_checks += 6;
      if (bus.pcF !== 32'(4 * k))       begin n_fail++; $display("FAIL seq_pcF k=%0d got %h want %h", k, bus.pcF, 32'(4 * k)); end
      if (bus.inst_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_inst_addr k=%0d got %h want %h", k, bus.inst_addr, 32'(4 * k)); end
      if (bus.inst_en !== 1'b1)         begin n_fail++; $display("FAIL seq_inst_en k=%0d got %b want 1", k, bus.inst_en); end
      if (bus.instrD !== e_instr)       begin n_fail++; $display("FAIL seq_instrD k=%0d got %h want %h", k, bus.instrD, e_instr); end
      if (bus.validD !== (k != 0))      begin n_fail++; $display("FAIL seq_validD k=%0d got %b want %b", k, bus.validD, k != 0); end
      if (bus.pcplus4D !== 32'(4 * k))  begin n_fail++; $display("FAIL seq_pcplus4D k=%0d got %h want %h", k, bus.pcplus4D, 32'(4 * k)); end
      advance();
    end
  endtask

  // Three-cycle stall while instrD = word 2; the D pair must not move.
  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
      n_checks += 5;
      if (bus.instrD !== 32'h1000_0002) begin n_fail++; $display("FAIL stall_instrD i=%0d got %h want 10000002", i, bus.instrD); end
      if (bus.pcplus4D !== 32'hC)       begin n_fail++; $display("FAIL stall_pcplus4D i=%0d got %h want c", i, bus.pcplus4D); end
      if (bus.pcF !== 32'hC)            begin n_fail++; $display("FAIL stall_pcF i=%0d got %h want c", i, bus.pcF); end
      if (bus.inst_en !== 1'b0)         begin n_fail++; $display("FAIL stall_inst_en i=%0d got %b want 0", i, bus.inst_en); end
      if (bus.validD !== 1'b1)          begin n_fail++; $display("FAIL stall_validD i=%0d got %b want 1", i, bus.validD); end
      advance();
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 3;
    if (bus.instrD !== 32'h1000_0002) begin n_fail++; $display("FAIL unstall_instrD got %h want 10000002", bus.instrD); end
    if (bus.pcF !== 32'hC)            begin n_fail++; $display("FAIL unstall_pcF got %h want c", bus.pcF); end
    if (bus.inst_en !== 1'b1)         begin n_fail++; $display("FAIL unstall_inst_en got %b want 1", bus.inst_en); end
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 3;
    if (bus.instrD !== 32'h1000_0003) begin n_fail++; $display("FAIL resume_instrD got %h want 10000003", bus.instrD); end
    if (bus.pcF !== 32'h10)           begin n_fail++; $display("FAIL resume_pcF got %h want 10", bus.pcF); end
    if (bus.pcplus4D !== 32'h10)      begin n_fail++; $display("FAIL resume_pcplus4D got %h want 10", bus.pcplus4D); end
    advance();
  endtask

  // Taken branch with flush of the wrong-path slot.
  task automatic test_branch();
    drive(0, 0, 1, 1, 32'h40, 0, 32'h0);
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 3;
    if (bus.instrD !== NOP_W) begin n_fail++; $display("FAIL br_flush_instrD got %h want %h", bus.instrD, NOP_W); end
    if (bus.validD !== 1'b0)  begin n_fail++; $display("FAIL br_flush_validD got %b want 0", bus.validD); end
    if (bus.pcF !== 32'h40)   begin n_fail++; $display("FAIL br_pcF got %h want 40", bus.pcF); end
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 3;
    if (bus.instrD !== 32'h1000_0010) begin n_fail++; $display("FAIL br_target_instrD got %h want 10000010", bus.instrD); end
    if (bus.pcplus4D !== 32'h44)      begin n_fail++; $display("FAIL br_target_pcplus4D got %h want 44", bus.pcplus4D); end
    if (bus.validD !== 1'b1)          begin n_fail++; $display("FAIL br_target_validD got %b want 1", bus.validD); end
    advance();
  endtask

  // Jump over branch, target alignment and PC wrap-around.
  task automatic test_priority();
    drive(0, 0, 1, 1, 32'h40, 1, 32'h80);
    advance();
    drive(0, 0, 1, 0, 32'h0, 1, 32'h83);
    n_checks++;
    if (bus.pcF !== 32'h80) begin n_fail++; $display("FAIL prio_jump_pcF got %h want 80", bus.pcF); end
    advance();
    drive(0, 0, 1, 1, 32'h42, 0, 32'h0);
    n_checks++;
    if (bus.pcF !== 32'h80) begin n_fail++; $display("FAIL align_jump_pcF got %h want 80", bus.pcF); end
    advance();
    drive(0, 0, 1, 0, 32'h0, 1, 32'hFFFF_FFFE);
    n_checks++;
    if (bus.pcF !== 32'h40) begin n_fail++; $display("FAIL align_br_pcF got %h want 40", bus.pcF); end
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 2;
    if (bus.pcF !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL top_pcF got %h want fffffffc", bus.pcF); end
    if (bus.validD !== 1'b0)       begin n_fail++; $display("FAIL top_validD got %b want 0", bus.validD); end
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 3;
    if (bus.pcF !== 32'h0)            begin n_fail++; $display("FAIL wrap_pcF got %h want 0", bus.pcF); end
    if (bus.instrD !== 32'h4FFF_FFFF) begin n_fail++; $display("FAIL wrap_instrD got %h want 4fffffff", bus.instrD); end
    if (bus.pcplus4D !== 32'h0)       begin n_fail++; $display("FAIL wrap_pcplus4D got %h want 0", bus.pcplus4D); end
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 2;
    if (bus.instrD !== 32'h1000_0000) begin n_fail++; $display("FAIL wrap_next_instrD got %h want 10000000", bus.instrD); end
    if (bus.pcplus4D !== 32'h4)       begin n_fail++; $display("FAIL wrap_next_pcplus4D got %h want 4", bus.pcplus4D); end
    advance();
  endtask

  // Redirect ignored under stallF; flush wins over stallD.
  task automatic test_stall_redirect();
    drive(1, 0, 0, 1, 32'h200, 0, 32'h0);
    n_checks++;
    if (bus.pcF !== 32'h8) begin n_fail++; $display("FAIL sr_pcF got %h want 8", bus.pcF); end
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 2;
    if (bus.pcF !== 32'h8)   begin n_fail++; $display("FAIL sr_ignored_pcF got %h want 8", bus.pcF); end
    if (bus.validD !== 1'b0) begin n_fail++; $display("FAIL sr_bubble_validD got %b want 0", bus.validD); end
    advance();
    drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
    n_checks += 2;
    if (bus.validD !== 1'b1)          begin n_fail++; $display("FAIL sf_pre_validD got %b want 1", bus.validD); end
    if (bus.instrD !== 32'h1000_0002) begin n_fail++; $display("FAIL sf_pre_instrD got %h want 10000002", bus.instrD); end
    advance();
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 3;
    if (bus.validD !== 1'b0) begin n_fail++; $display("FAIL sf_validD got %b want 0", bus.validD); end
    if (bus.instrD !== NOP_W) begin n_fail++; $display("FAIL sf_instrD got %h want %h", bus.instrD, NOP_W); end
    if (bus.pcF !== 32'hC)    begin n_fail++; $display("FAIL sf_pcF got %h want c", bus.pcF); end
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks++;
    if (bus.instrD !== NOP_W) begin n_fail++; $display("FAIL sf_release_instrD got %h want %h", bus.instrD, NOP_W); end
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 2;
    if (bus.instrD !== 32'h1000_0003) begin n_fail++; $display("FAIL sf_resume_instrD got %h want 10000003", bus.instrD); end
    if (bus.validD !== 1'b1)          begin n_fail++; $display("FAIL sf_resume_validD got %b want 1", bus.validD); end
    advance();
  endtask

  // Random hazards and redirects against the reference model.
  task automatic test_random(input int n);
    logic stf, std, fl, br, jp;
    logic [31:0] bt, jt;
    for (int i = 0; i < n; i++) begin
      std = ($urandom_range(0, 4) == 0);
      stf = std | ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      br  = ($urandom_range(0, 4) == 0);
      jp  = ($urandom_range(0, 7) == 0);
      bt  = $urandom;
      jt  = $urandom;
      drive(stf, std, fl, br, bt, jp, jt);
      n_checks += 6;
      if (bus.pcF !== m_pc)          begin n_fail++; $display("FAIL rnd_pcF i=%0d got %h want %h", i, bus.pcF, m_pc); end
      if (bus.inst_addr !== m_pc)    begin n_fail++; $display("FAIL rnd_inst_addr i=%0d got %h want %h", i, bus.inst_addr, m_pc); end
      if (bus.inst_en !== !stf)      begin n_fail++; $display("FAIL rnd_inst_en i=%0d got %b want %b", i, bus.inst_en, !stf); end
      if (bus.instrD !== m_dinstr)   begin n_fail++; $display("FAIL rnd_instrD i=%0d got %h want %h", i, bus.instrD, m_dinstr); end
      if (bus.validD !== m_dvalid)   begin n_fail++; $display("FAIL rnd_validD i=%0d got %b want %b", i, bus.validD, m_dvalid); end
      if (bus.pcplus4D !== m_dpc4)   begin n_fail++; $display("FAIL rnd_pcplus4D i=%0d got %h want %h", i, bus.pcplus4D, m_dpc4); end
      advance();
    end
  endtask

  // Asynchronous reset in the second cycle of a stall with the skid register loaded.
  task automatic test_reset_mid_stall();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    advance();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    advance();
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    advance();
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    n_checks += 2;
    if (bus.validD !== 1'b1)       begin n_fail++; $display("FAIL rms_pre_validD got %b want 1", bus.validD); end
    if (bus.instrD !== m_dinstr)   begin n_fail++; $display("FAIL rms_pre_instrD got %h want %h", bus.instrD, m_dinstr); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks += 5;
    if (bus.pcF !== RST_PC)     begin n_fail++; $display("FAIL rms_pcF got %h want %h", bus.pcF, RST_PC); end
    if (bus.instrD !== NOP_W)   begin n_fail++; $display("FAIL rms_instrD got %h want %h", bus.instrD, NOP_W); end
    if (bus.validD !== 1'b0)    begin n_fail++; $display("FAIL rms_validD got %b want 0", bus.validD); end
    if (bus.inst_en !== 1'b0)   begin n_fail++; $display("FAIL rms_inst_en got %b want 0", bus.inst_en); end
    if (bus.pcplus4D !== 32'h0) begin n_fail++; $display("FAIL rms_pcplus4D got %h want 0", bus.pcplus4D); end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.stallF = 1'b0; bus.stallD = 1'b0; bus.flushD = 1'b0;
    bus.pcsrcD = 1'b0; bus.pcbranchD = 32'h0;
    bus.jumpD  = 1'b0; bus.pcjumpD   = 32'h0;
    model_reset();
    test_reset();
    test_sequential(3);
    test_stall();
    test_branch();
    test_priority();
    test_stall_redirect();
    test_random(300);
    test_reset_mid_stall();
    test_sequential(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
